segdisp_scan: RTL and testbench

Time-multiplexed driver for an 8-digit hexadecimal 7-segment display. It takes the 32-bit key-buffer value, snapshots it at each frame boundary and scans the nibbles one digit at a time onto shared segment lines. Optional leading-zero blanking is supported. It sits between the key-input buffer output and the board's display pins, and is the consumer of the value that the key buffer shifts in.

---
 rtl/segdisp_pkg.sv | 34 +++
 rtl/segdisp_scan_if.sv | 29 ++
 rtl/seg7_dec.sv | 13 +
 rtl/segdisp_scan.sv | 137 +++++++++++++
 tb/tb_segdisp_scan.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/segdisp_pkg.sv
// segdisp_pkg: shared constants for the 8-digit hex 7-segment scanner.
//   NDIGIT         - number of scanned digits
//   SEG_W          - number of segment lines, ordered {g,f,e,d,c,b,a}
//   seg_bit_e      - bit position of each segment within a pattern
//   HEX_SEG_TABLE  - active-high pattern for each hex nibble
//   hex_to_seg()   - table lookup helper
package segdisp_pkg;

    localparam int NDIGIT = 8;
    localparam int SEG_W  = 7;

    // Segment a is bit 0 and segment g is bit 6.
    typedef enum int unsigned {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam logic [SEG_W-1:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/segdisp_scan_if.sv
// segdisp_scan_if: signal bundle between the key-buffer side and the scanner.
//   in         - 32-bit value to display (in[3:0] is digit 0)
//   enable     - scan enable
//   blank_zero - leading-zero suppression enable
//   seg        - segment lines {g,f,e,d,c,b,a}, pin polarity
//   dig        - digit selects, pin polarity
//   frame      - one-cycle pulse at the start of each frame
// master drives the value and controls; slave is the scanner itself.
interface segdisp_scan_if;
    import segdisp_pkg::*;

    logic [31:0]       in;
    logic              enable;
    logic              blank_zero;
    logic [SEG_W-1:0]  seg;
    logic [NDIGIT-1:0] dig;
    logic              frame;

    modport master (
        output in, enable, blank_zero,
        input  seg, dig, frame
    );

    modport slave (
        input  in, enable, blank_zero,
        output seg, dig, frame
    );

endinterface

// File: rtl/seg7_dec.sv
// seg7_dec: combinational hex nibble to 7-segment decoder.
//   nibble  - 4-bit hex digit
//   pattern - active-high segments {g,f,e,d,c,b,a}
module seg7_dec
    import segdisp_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] pattern
);

    assign pattern = hex_to_seg(nibble);

endmodule

// File: rtl/segdisp_scan.sv
// segdisp_scan: time-multiplexed driver for an 8-digit hex 7-segment display.
//   clock - system clock, all state changes on the rising edge
//   reset - synchronous, active-high
//   bus   - slave side of segdisp_scan_if (in/enable/blank_zero in,
//           seg/dig/frame out)
// Each digit dwells DIV cycles: one dark cycle against ghosting, then DIV-1
// lit cycles. The displayed value is snapshotted at frame boundaries.
module segdisp_scan
    import segdisp_pkg::*;
#(
    parameter int DIV        = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic           clock,
    input logic           reset,
    segdisp_scan_if.slave bus
);

    localparam int                 PCNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PCNT_W-1:0]  PCNT_LAST = PCNT_W'(DIV - 1);
    localparam logic [SEG_W-1:0]   SEG_IDLE  = {SEG_W{ACTIVE_LOW}};
    localparam logic [NDIGIT-1:0]  DIG_IDLE  = {NDIGIT{ACTIVE_LOW}};

    logic [PCNT_W-1:0] pcnt;
    logic [2:0]        idx;
    logic [31:0]       snap;
    logic              wrap_d;
    logic              tick;
    logic              last_tick;

    logic [3:0]        nibble;
    logic [SEG_W-1:0]  pattern;
    logic [NDIGIT-1:0] lead_zero;
    logic              blank_cur;
    logic [SEG_W-1:0]  seg_next;
    logic [NDIGIT-1:0] dig_next;

    logic [SEG_W-1:0]  seg_q;
    logic [NDIGIT-1:0] dig_q;
    logic              frame_q;

    assign tick      = (pcnt == PCNT_LAST) && bus.enable;
    assign last_tick = tick && (idx == 3'd7);

    // Prescaler and digit index; both are parked at zero while disabled so
    // that every enabled run starts on the dark cycle of digit 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (!bus.enable) begin
            pcnt <= '0;
            idx  <= '0;
        end else begin
            pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Snapshot follows the input while dark and is otherwise refreshed only
    // on the final tick of a frame, so a frame never shows a torn value.
    always_ff @(posedge clock) begin
        if (reset) begin
            snap <= '0;
        end else if (!bus.enable || last_tick) begin
            snap <= bus.in;
        end
    end

    // wrap_d marks the cycle whose registered output is the dark cycle of
    // digit 0 of a new frame; it only exists after a real frame wrap, so a
    // restart from enable or reset never produces a frame pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrap_d <= 1'b0;
        end else begin
            wrap_d <= last_tick;
        end
    end

    assign nibble = snap[4*idx +: 4];

    seg7_dec u_dec (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // lead_zero[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        logic all_zero;
        lead_zero = '0;
        all_zero  = 1'b1;
        for (int i = NDIGIT - 1; i >= 0; i--) begin
            all_zero     = all_zero && (snap[4*i +: 4] == 4'h0);
            lead_zero[i] = all_zero;
        end
    end

    assign blank_cur = bus.blank_zero && (idx != 3'd0) && lead_zero[idx];

    // Next output values in pin polarity; dark whenever disabled, and the
    // digit select is withheld on the first cycle of each dwell.
    always_comb begin
        logic [SEG_W-1:0]  seg_on;
        logic [NDIGIT-1:0] dig_on;
        seg_on = '0;
        dig_on = '0;
        if (bus.enable) begin
            seg_on = blank_cur ? '0 : pattern;
            if (pcnt != '0) begin
                dig_on = NDIGIT'(1) << idx;
            end
        end
        seg_next = seg_on ^ SEG_IDLE;
        dig_next = dig_on ^ DIG_IDLE;
    end

    // Output registers, reset to the inactive level of the chosen polarity.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q   <= SEG_IDLE;
            dig_q   <= DIG_IDLE;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_next;
            dig_q   <= dig_next;
            frame_q <= wrap_d && bus.enable;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dig   = dig_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_segdisp_scan.sv
// tb_segdisp_scan: self-checking bench for segdisp_scan with DIV=4.
// Two instances share the same stimulus, one active-high and one active-low;
// the active-low outputs must be the bitwise inverse of the active-high ones.
// Expected values come from a position-in-frame model of the display.
module tb_segdisp_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        blank_zero;
    logic [31:0] in_val;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_ref [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int          pos;
    logic [31:0] m_snap;
    logic [6:0]  exp_seg;
    logic [7:0]  exp_dig;
    logic        exp_frame;

    segdisp_scan_if bus_hi ();
    segdisp_scan_if bus_lo ();

    assign bus_hi.in         = in_val;
    assign bus_hi.enable     = enable;
    assign bus_hi.blank_zero = blank_zero;
    assign bus_lo.in         = in_val;
    assign bus_lo.enable     = enable;
    assign bus_lo.blank_zero = blank_zero;

    segdisp_scan #(.DIV(DIV), .ACTIVE_LOW(1'b0)) u_hi (
        .clock (clock),
        .reset (reset),
        .bus   (bus_hi)
    );

    segdisp_scan #(.DIV(DIV), .ACTIVE_LOW(1'b1)) u_lo (
        .clock (clock),
        .reset (reset),
        .bus   (bus_lo)
    );

    always #5 clock = ~clock;

    // Model: pos counts enabled cycles since the scan last restarted; the
    // digit, dwell slot and frame boundary follow from it by division.
    task automatic modelStep();
        int         d;
        int         slot;
        logic [3:0] nib;
        logic       blank;
        if (reset) begin
            exp_seg   = '0;
            exp_dig   = '0;
            exp_frame = 1'b0;
            m_snap    = '0;
            pos       = 0;
        end else if (!enable) begin
            exp_seg   = '0;
            exp_dig   = '0;
            exp_frame = 1'b0;
            m_snap    = in_val;
            pos       = 0;
        end else begin
            d     = (pos / DIV) % 8;
            slot  = pos % DIV;
            nib   = m_snap[4*d +: 4];
            blank = blank_zero && (d != 0) && ((m_snap >> (4 * d)) == 32'h0);
            exp_dig   = (slot == 0) ? 8'h00 : 8'(1 << d);
            exp_seg   = blank ? 7'h00 : seg_ref[nib];
            exp_frame = (pos > 0) && (pos % FRAME == 0);
            if (pos % FRAME == FRAME - 1) begin
                m_snap = in_val;
            end
            pos++;
        end
    endtask

    task automatic checkOutput();
        checks++;
        assert (bus_hi.seg === exp_seg) else begin
            errors++;
            $error("[TB] FAIL seg_hi observed=%h expected=%h pos=%0d", bus_hi.seg, exp_seg, pos);
        end
        checks++;
        assert (bus_hi.dig === exp_dig) else begin
            errors++;
            $error("[TB] FAIL dig_hi observed=%h expected=%h pos=%0d", bus_hi.dig, exp_dig, pos);
        end
        checks++;
        assert (bus_hi.frame === exp_frame) else begin
            errors++;
            $error("[TB] FAIL frame_hi observed=%b expected=%b pos=%0d", bus_hi.frame, exp_frame, pos);
        end
        checks++;
        assert (bus_lo.seg === ~exp_seg) else begin
            errors++;
            $error("[TB] FAIL seg_lo observed=%h expected=%h pos=%0d", bus_lo.seg, ~exp_seg, pos);
        end
        checks++;
        assert (bus_lo.dig === ~exp_dig) else begin
            errors++;
            $error("[TB] FAIL dig_lo observed=%h expected=%h pos=%0d", bus_lo.dig, ~exp_dig, pos);
        end
        checks++;
        assert (bus_lo.frame === exp_frame) else begin
            errors++;
            $error("[TB] FAIL frame_lo observed=%b expected=%b pos=%0d", bus_lo.frame, exp_frame, pos);
        end
    endtask

    // Drive one cycle of inputs, step the model at the rising edge and
    // compare on the following falling edge.
    task automatic applyStimulus(input logic r, input logic e, input logic bz,
                                 input logic [31:0] v, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            reset      = r;
            enable     = e;
            blank_zero = bz;
            in_val     = v;
            @(posedge clock);
            modelStep();
            @(negedge clock);
            checkOutput();
        end
    endtask

    function automatic logic [31:0] randValue();
        int          z;
        logic [31:0] v;
        v = $urandom;
        z = $urandom_range(0, 8);
        if (z == 8) begin
            return 32'h0;
        end
        return v >> (4 * z);
    endfunction

    initial begin
        logic [31:0] rv;
        logic        bz;
        int          guard;

        pos    = 0;
        m_snap = '0;

        $display("[TB] reset held with enable high");
        applyStimulus(1'b1, 1'b1, 1'b0, $urandom, 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 10);

        $display("[TB] full hex pattern from an enable rise");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h89ABCDEF, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h89ABCDEF, 2 * FRAME + 4);

        $display("[TB] leading-zero blanking");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000050, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h00000050, FRAME + 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000000, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h00000000, FRAME + 2);

        $display("[TB] mid-frame input change");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h11111111, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h11111111, 3 * DIV + 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h22222222, 2 * FRAME);

        $display("[TB] enable drop during digit 5");
        guard = 0;
        while (((pos / DIV) % 8 != 5 || pos % DIV != 2) && guard < 2 * FRAME) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h22222222, 1);
            guard++;
        end
        checks++;
        assert (guard < 2 * FRAME) else begin
            errors++;
            $error("[TB] FAIL reach_digit5 observed=%0d expected<%0d", guard, 2 * FRAME);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h3456789A, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h3456789A, FRAME + 4);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h3456789A, 9);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h3456789A, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h3456789A, FRAME + 2);

        $display("[TB] randomized run");
        rv = randValue();
        bz = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                rv = randValue();
            end
            if ($urandom_range(0, 15) == 0) begin
                bz = ~bz;
            end
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) != 0), bz, rv, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
